// File: rtl/ahb_result_pkg.sv
// Shared definitions for the AHB result port: register offsets, AHB
// encodings, result FSM states and bus data-phase states.
package ahb_result_pkg;

  localparam logic [4:0] OFF_EXPECT  = 5'h00;
  localparam logic [4:0] OFF_STATUS  = 5'h04;
  localparam logic [4:0] OFF_RESULT  = 5'h08;
  localparam logic [4:0] OFF_WCOUNT  = 5'h0C;
  localparam logic [4:0] OFF_SCRATCH = 5'h10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } result_state_e;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_WAIT = 3'd1,
    PH_DATA = 3'd2,
    PH_ERR1 = 3'd3,
    PH_ERR2 = 3'd4
  } bus_phase_e;

  function automatic logic is_read_only(input logic [4:0] off);
    return (off == OFF_STATUS) || (off == OFF_WCOUNT);
  endfunction

endpackage

// File: rtl/ahb_result_if.sv
// AHB-Lite slave-side signal bundle for the result port.
interface ahb_result_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_result_watchdog.sv
// Free-running watchdog for the result port: counts enabled cycles and
// flags expiry when the count reaches LIMIT-1.
module result_watchdog #(
  parameter logic [19:0] LIMIT = 20'd100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [19:0] count_q;

  // Cycle counter; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= '0;
    else if (clr)    count_q <= '0;
    else if (en)     count_q <= count_q + 20'd1;
  end

  assign expired = en && (count_q == LIMIT - 20'd1);

endmodule

// File: rtl/ahb_result_port.sv
// AHB-Lite test result port: EXPECT/STATUS/RESULT/WCOUNT/SCRATCH window,
// pass/fail/timeout FSM and watchdog.
// Optional build macro RESULT_PORT_WAIT_EN: one wait state per valid transfer.
//
// state | meaning
// RUN   | test running, watchdog counting
// PASS  | RESULT matched EXPECT (terminal)
// FAIL  | RESULT differed from EXPECT (terminal)
// TOUT  | watchdog expired before any RESULT write (terminal)
module ahb_result_port
  import ahb_result_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0050,
  parameter logic [31:0] EXPECT_RESET   = 32'h2FFF_FFFE,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_result_if.slave  bus,
  output logic         done,
  output logic         pass,
  output logic         timeout
);

`ifdef RESULT_PORT_WAIT_EN
  localparam bus_phase_e PH_ACCEPT = PH_WAIT;
`else
  localparam bus_phase_e PH_ACCEPT = PH_DATA;
`endif

  bus_phase_e    phase_q, phase_d;
  result_state_e state_q, state_d;
  logic [4:0]    dp_off_q;
  logic          dp_write_q;
  logic [31:0]   expect_q, scratch_q, wcount_q;
  logic [31:0]   addr_off;
  logic          addr_trans, addr_open, addr_valid, addr_err;
  logic          wr_commit, result_wr, wd_expired;

  // Address-phase qualification; illegal accesses are flagged here so the
  // data phase never touches a register on error.
  assign addr_off   = bus.HADDR - BASE_ADDR;
  assign addr_trans = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
  assign addr_open  = (phase_q == PH_IDLE) || (phase_q == PH_DATA) || (phase_q == PH_ERR2);
  assign addr_valid = bus.HSEL && bus.HREADY && addr_trans && addr_open;
  assign addr_err   = (addr_off > 32'(OFF_SCRATCH)) || (addr_off[1:0] != 2'b00) ||
                      (bus.HSIZE != HSIZE_WORD) ||
                      (bus.HWRITE && is_read_only(addr_off[4:0]));

  // Data-phase sequencing: wait state (optional), data, or two-cycle error.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_WAIT: phase_d = PH_DATA;
      PH_ERR1: phase_d = PH_ERR2;
      default: begin
        if (addr_valid) phase_d = addr_err ? PH_ERR1 : PH_ACCEPT;
        else            phase_d = PH_IDLE;
      end
    endcase
  end

  // Bus phase register and captured address-phase attributes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      phase_q    <= PH_IDLE;
      dp_off_q   <= '0;
      dp_write_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (addr_valid) begin
        dp_off_q   <= addr_off[4:0];
        dp_write_q <= bus.HWRITE;
      end
    end
  end

  assign bus.HREADYOUT = !((phase_q == PH_WAIT) || (phase_q == PH_ERR1));
  assign bus.HRESP     = ((phase_q == PH_ERR1) || (phase_q == PH_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign wr_commit     = (phase_q == PH_DATA) && dp_write_q;
  assign result_wr     = wr_commit && (dp_off_q == OFF_RESULT);

  // Read mux, only driven during a valid read data phase.
  always_comb begin
    bus.HRDATA = '0;
    if (((phase_q == PH_DATA) || (phase_q == PH_WAIT)) && !dp_write_q) begin
      case (dp_off_q)
        OFF_EXPECT:  bus.HRDATA = expect_q;
        OFF_STATUS:  bus.HRDATA = {28'b0, timeout, (state_q == ST_FAIL), pass, done};
        OFF_WCOUNT:  bus.HRDATA = wcount_q;
        OFF_SCRATCH: bus.HRDATA = scratch_q;
        default:     bus.HRDATA = '0;
      endcase
    end
  end

  // Register file writes commit at the end of the ready data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      expect_q  <= EXPECT_RESET;
      scratch_q <= '0;
      wcount_q  <= '0;
    end else if (wr_commit) begin
      wcount_q <= wcount_q + 32'd1;
      if (dp_off_q == OFF_EXPECT)  expect_q  <= bus.HWDATA;
      if (dp_off_q == OFF_SCRATCH) scratch_q <= bus.HWDATA;
    end
  end

  // Result FSM next state; a RESULT write beats a same-cycle expiry.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (result_wr)       state_d = (bus.HWDATA == expect_q) ? ST_PASS : ST_FAIL;
      else if (wd_expired) state_d = ST_TOUT;
    end
  end

  // Result FSM state and registered status outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d != ST_RUN);
      pass    <= (state_d == ST_PASS);
      timeout <= (state_d == ST_TOUT);
    end
  end

  result_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .en      (state_q == ST_RUN),
    .clr     (state_q != ST_RUN),
    .expired (wd_expired)
  );

endmodule

// File: tb/tb_ahb_result_port.sv
// Self-checking bench for ahb_result_port with a register-map reference model.
`timescale 1ns/1ps
module tb_ahb_result_port;
  import ahb_result_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_0050;
  localparam logic [31:0] EXP_RST = 32'h2FFF_FFFE;
`ifdef RESULT_PORT_WAIT_EN
  localparam int EXP_WAITS = 1;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done, pass, timeout;
  logic wd_done, wd_pass, wd_timeout;
  int n_checks = 0;
  int n_fail = 0;

  // reference model: 0 running, 1 pass, 2 fail, 3 timeout
  logic [31:0] m_expect, m_scratch, m_wcount;
  int m_state;

  ahb_result_if bus();
  ahb_result_if wd_bus();
  assign bus.HREADY    = bus.HREADYOUT;
  assign wd_bus.HREADY = wd_bus.HREADYOUT;

  always #5 clk = ~clk;

  ahb_result_port dut (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus),
    .done(done), .pass(pass), .timeout(timeout)
  );

  ahb_result_port #(.TIMEOUT_CYCLES(20'd16)) dut_wd (
    .HCLK(clk), .HRESETn(rst_n), .bus(wd_bus),
    .done(wd_done), .pass(wd_pass), .timeout(wd_timeout)
  );

  function automatic bit m_err(input logic wr, input logic [31:0] off, input logic [2:0] size);
    return (off > 32'h10) || (off % 4 != 0) || (size != 3'b010) ||
           (wr && (off == 32'h4 || off == 32'hC));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] off);
    case (off)
      32'h00: return m_expect;
      32'h04: return {28'd0, m_state == 3, m_state == 2, m_state == 1, m_state != 0};
      32'h0C: return m_wcount;
      32'h10: return m_scratch;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_write(input logic [31:0] off, input logic [31:0] data);
    m_wcount = m_wcount + 1;
    if (off == 32'h00) m_expect = data;
    if (off == 32'h10) m_scratch = data;
    if (off == 32'h08 && m_state == 0) m_state = (data == m_expect) ? 1 : 2;
  endfunction

  task automatic bus_idle();
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HWDATA = '0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_expect = EXP_RST; m_scratch = '0; m_wcount = '0; m_state = 0;
  endtask

  // Single non-pipelined transfer; resp = {HRESP first data cycle, HRESP ready cycle}.
  task automatic xfer(input logic wr, input logic [31:0] off, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic [1:0] resp, output int waits);
    bus.HSEL = 1'b1; bus.HADDR = BASE + off; bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = wr; bus.HSIZE = size;
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWDATA = wdata;
    resp[1] = bus.HRESP;
    waits = 0;
    while (bus.HREADYOUT !== 1'b1 && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 8) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_ready: HREADYOUT stuck at %b, required 1", bus.HREADYOUT);
    end
    resp[0] = bus.HRESP;
    rdata = bus.HRDATA;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic [1:0] rsp; int w;
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.HREADYOUT, bus.HRESP, done, pass, timeout, wd_done, wd_timeout} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 1000000",
        {bus.HREADYOUT, bus.HRESP, done, pass, timeout, wd_done, wd_timeout});
    end
    n_checks++;
    if (bus.HRDATA !== 32'd0) begin n_fail++; $display("FAIL reset_hrdata: got %h required 0", bus.HRDATA); end
    rst_n = 1'b1;
    m_expect = EXP_RST; m_scratch = '0; m_wcount = '0; m_state = 0;
    xfer(1'b0, 32'h00, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== EXP_RST) begin n_fail++; $display("FAIL reset_expect: got %h required %h", rd, EXP_RST); end
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_scratch: got %h required 0", rd); end
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h required 0", rd); end
  endtask

  task automatic test_pass();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    xfer(1'b1, 32'h08, HSIZE_WORD, EXP_RST, rd, rsp, w);
    n_checks++;
    if (rsp !== 2'b00 || w !== EXP_WAITS) begin
      n_fail++; $display("FAIL pass_resp: got resp %b waits %0d required 00 %0d", rsp, w, EXP_WAITS);
    end
    n_checks++;
    if ({timeout, pass, done} !== 3'b011) begin
      n_fail++; $display("FAIL pass_flags: got %b required 011", {timeout, pass, done});
    end
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("FAIL pass_status: got %h required 3", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    bus.HSEL = 1'b1; bus.HADDR = BASE + 32'h00; bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b1; bus.HSIZE = HSIZE_WORD;
    @(posedge clk); #1;
    bus.HWDATA = 32'd7; bus.HADDR = BASE + 32'h08;
    w = 0;
    while (bus.HREADYOUT !== 1'b1 && w < 8) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWDATA = 32'd7;
    while (bus.HREADYOUT !== 1'b1 && w < 16) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    n_checks++;
    if (w !== 2 * EXP_WAITS) begin n_fail++; $display("FAIL b2b_waits: got %0d required %0d", w, 2 * EXP_WAITS); end
    n_checks++;
    if ({timeout, pass, done} !== 3'b011) begin
      n_fail++; $display("FAIL b2b_pass: got %b required 011", {timeout, pass, done});
    end
    xfer(1'b0, 32'h0C, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd2) begin n_fail++; $display("FAIL b2b_wcount: got %0d required 2", rd); end
  endtask

  task automatic test_fail();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    xfer(1'b1, 32'h08, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if ({timeout, pass, done} !== 3'b001) begin
      n_fail++; $display("FAIL fail_flags: got %b required 001", {timeout, pass, done});
    end
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'h5) begin n_fail++; $display("FAIL fail_status: got %h required 5", rd); end
    xfer(1'b1, 32'h08, HSIZE_WORD, EXP_RST, rd, rsp, w);
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'h5 || pass !== 1'b0) begin
      n_fail++; $display("FAIL fail_sticky: got status %h pass %b required 5 0", rd, pass);
    end
    xfer(1'b0, 32'h0C, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd2) begin n_fail++; $display("FAIL fail_wcount: got %0d required 2", rd); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if ({wd_timeout, wd_done} !== 2'b00) begin
      n_fail++; $display("FAIL tout_early: got %b at cycle 16 required 00", {wd_timeout, wd_done});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({wd_timeout, wd_pass, wd_done} !== 3'b101) begin
      n_fail++; $display("FAIL tout_flags: got %b at cycle 17 required 101", {wd_timeout, wd_pass, wd_done});
    end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL tout_default: done %b required 0", done); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'hA5A5_1234, rd, rsp, w);
    n_checks++;
    if (rsp !== 2'b00 || w !== EXP_WAITS) begin
      n_fail++; $display("FAIL scratch_wr_waits: got resp %b waits %0d required 00 %0d", rsp, w, EXP_WAITS);
    end
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'hA5A5_1234 || w !== EXP_WAITS) begin
      n_fail++; $display("FAIL scratch_rd: got %h waits %0d required a5a51234 %0d", rd, w, EXP_WAITS);
    end
    xfer(1'b0, 32'h14, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rsp !== 2'b11 || w !== 1) begin
      n_fail++; $display("FAIL err_rd14: got resp %b waits %0d required 11 1", rsp, w);
    end
    xfer(1'b1, 32'h04, HSIZE_WORD, 32'hFFFF_FFFF, rd, rsp, w);
    n_checks++;
    if (rsp !== 2'b11 || w !== 1) begin
      n_fail++; $display("FAIL err_wr_status: got resp %b waits %0d required 11 1", rsp, w);
    end
    xfer(1'b1, 32'h00, 3'b000, 32'h1, rd, rsp, w);
    n_checks++;
    if (rsp !== 2'b11) begin n_fail++; $display("FAIL err_size: got resp %b required 11", rsp); end
    xfer(1'b0, 32'h0C, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL err_wcount: got %0d required 1", rd); end
    xfer(1'b0, 32'h00, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== EXP_RST) begin n_fail++; $display("FAIL err_expect: got %h required %h", rd, EXP_RST); end
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL err_status: got %h required 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    bus.HSEL = 1'b1; bus.HADDR = BASE + 32'h08; bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b1; bus.HSIZE = HSIZE_WORD;
    @(posedge clk); #1;
    bus_idle();
    bus.HWDATA = EXP_RST;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.HREADYOUT, bus.HRESP, done, pass, timeout} !== 5'b10000 || bus.HRDATA !== 32'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b rdata %h required 10000 0",
        {bus.HREADYOUT, bus.HRESP, done, pass, timeout}, bus.HRDATA);
    end
    bus.HWDATA = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_expect = EXP_RST; m_scratch = '0; m_wcount = '0; m_state = 0;
    n_checks++;
    if ({done, pass, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags: got %b required 000", {done, pass, timeout});
    end
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL midrst_status: got %h required 0", rd); end
    xfer(1'b0, 32'h0C, HSIZE_WORD, 32'd0, rd, rsp, w);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL midrst_wcount: got %0d required 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] offs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h02, 32'h40};
    logic [31:0] rd, off, data, exp_rd; logic [1:0] rsp; int w;
    logic wr, err; logic [2:0] size;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      off  = offs[$urandom_range(0, 7)];
      wr   = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      data = $urandom;
      if (off == 32'h08 && $urandom_range(0, 1) == 1) data = m_expect;
      err = m_err(wr, off, size);
      exp_rd = m_read(off);
      xfer(wr, off, size, data, rd, rsp, w);
      n_checks++;
      if (rsp !== (err ? 2'b11 : 2'b00) || w !== (err ? 1 : EXP_WAITS)) begin
        n_fail++; $display("FAIL rnd_resp[%0d]: off %h got resp %b waits %0d required err=%0d",
          i, off, rsp, w, err);
      end
      if (!err && !wr) begin
        n_checks++;
        if (rd !== exp_rd) begin
          n_fail++; $display("FAIL rnd_rdata[%0d]: off %h got %h required %h", i, off, rd, exp_rd);
        end
      end
      if (!err && wr) m_write(off, data);
      n_checks++;
      if ({timeout, pass, done} !== {m_state == 3, m_state == 1, m_state != 0}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got %b required %b", i, {timeout, pass, done},
          {m_state == 3, m_state == 1, m_state != 0});
      end
    end
  endtask

  initial begin
    wd_bus.HSEL = 1'b0; wd_bus.HADDR = '0; wd_bus.HTRANS = HTRANS_IDLE;
    wd_bus.HWRITE = 1'b0; wd_bus.HSIZE = HSIZE_WORD; wd_bus.HWDATA = '0;
    bus_idle();
    test_reset();
    test_pass();
    test_back_to_back();
    test_fail();
    test_timeout();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench time limit");
  end

endmodule
